// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  function automatic int unsigned gid_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned m);
    return (m > 0) ? $clog2(m + 1) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping.
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned GW   = gid_width(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [GW-1:0]   ptr_i,
  output logic [GW-1:0]   gnt_o,
  output logic            any_o
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [GW-1:0]     off;
  logic              found;
  logic [GW:0]       sum;

  // Rotating a doubled copy puts the request at ptr_i in bit 0.
  assign dbl   = {req_i, req_i} >> ptr_i;
  assign rot   = dbl[NREQ-1:0];
  assign any_o = |req_i;

  always_comb begin
    off   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (rot[k] && !found) begin
        off   = GW'(k);
        found = 1'b1;
      end
    end
    sum = (GW+1)'(ptr_i) + (GW+1)'(off);
    if (sum >= (GW+1)'(NREQ)) begin
      sum = sum - (GW+1)'(NREQ);
    end
    gnt_o = sum[GW-1:0];
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter sharing the FIFO memory write port among NREQ producers.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned DATASIZE = 8,
  parameter int unsigned MAXBURST = 4,
  localparam int unsigned GW      = gid_width(NREQ)
) (
  input  logic                     wclk,
  input  logic                     wrst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DATASIZE-1:0] req_data,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     wfull,
  output logic                     wclken,
  output logic [DATASIZE-1:0]      wdata,
  output logic [GW-1:0]            grant_id,
  output logic                     busy
);

  localparam int unsigned CW = cnt_width(MAXBURST);

  arb_state_e    state_q, state_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] arb_idx;
  logic          any_req;
  logic          beat;

  rr_arbiter #(.NREQ(NREQ), .GW(GW)) u_rr (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_idx),
    .any_o (any_req)
  );

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    beat      = 1'b0;
    req_ready = '0;
    wclken    = 1'b0;
    wdata     = '0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = arb_idx;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        beat               = req_valid[grant_q] & ~wfull;
        wclken             = beat;
        req_ready[grant_q] = beat;
        wdata              = req_data[grant_q*DATASIZE +: DATASIZE];
        if (beat) begin
          if (req_last[grant_q] || (cnt_q == CW'(MAXBURST - 1))) begin
            state_d  = IDLE;
            cnt_d    = '0;
            rr_ptr_d = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q == GRANT);
  assign grant_id = grant_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench: directed scenarios plus randomized traffic against a burst-level reference model.
module tb_fifo_wr_arb;

  logic        wclk;
  logic        rst_n;
  logic [3:0]  valid;
  logic [31:0] data;
  logic [3:0]  last;
  logic        full;

  logic [3:0] ready_a, ready_b;
  logic       wclken_a, wclken_b, busy_a, busy_b;
  logic [7:0] wdata_a, wdata_b;
  logic [1:0] grant_a, grant_b;
  logic [15:0] obs_a, obs_b;

  int checks = 0;
  int passes = 0;

  fifo_wr_arb #(.NREQ(4), .DATASIZE(8), .MAXBURST(4)) dut_a (
    .wclk(wclk), .wrst_n(rst_n), .req_valid(valid), .req_data(data), .req_last(last),
    .req_ready(ready_a), .wfull(full), .wclken(wclken_a), .wdata(wdata_a),
    .grant_id(grant_a), .busy(busy_a)
  );

  fifo_wr_arb #(.NREQ(4), .DATASIZE(8), .MAXBURST(1)) dut_b (
    .wclk(wclk), .wrst_n(rst_n), .req_valid(valid), .req_data(data), .req_last(last),
    .req_ready(ready_b), .wfull(full), .wclken(wclken_b), .wdata(wdata_b),
    .grant_id(grant_b), .busy(busy_b)
  );

  assign obs_a = {busy_a, wclken_a, grant_a, ready_a, wdata_a};
  assign obs_b = {busy_b, wclken_b, grant_b, ready_b, wdata_b};

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  // Reference model: owner = requester holding the port (-1 when none).
  typedef struct {
    int owner;
    int cnt;
    int ptr;
    int gid;
  } mdl_t;

  mdl_t ma = '{-1, 0, 0, 0};
  mdl_t mb = '{-1, 0, 0, 0};

  function automatic logic [15:0] expect_out(mdl_t m, logic [3:0] v, logic f, logic [31:0] d);
    logic       bt;
    logic [7:0] wd;
    if (m.owner < 0) return {2'b00, 2'(m.gid), 4'b0000, 8'h00};
    bt = v[m.owner] && !f;
    wd = d[m.owner*8 +: 8];
    return {1'b1, bt, 2'(m.gid), bt ? 4'(1 << m.owner) : 4'b0000, wd};
  endfunction

  function automatic mdl_t advance(mdl_t m, int maxb, logic [3:0] v, logic [3:0] l, logic f);
    mdl_t n;
    bit   found;
    n = m;
    found = 0;
    if (m.owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        if (!found && v[(m.ptr + k) % 4]) begin
          n.owner = (m.ptr + k) % 4;
          n.gid   = n.owner;
          n.cnt   = 0;
          found   = 1;
        end
      end
    end else if (v[m.owner] && !f) begin
      n.cnt = m.cnt + 1;
      if (l[m.owner] || n.cnt == maxb) begin
        n.owner = -1;
        n.ptr   = (m.gid + 1) % 4;
        n.cnt   = 0;
      end
    end
    return n;
  endfunction

  always @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= '{-1, 0, 0, 0};
      mb <= '{-1, 0, 0, 0};
    end else begin
      ma <= advance(ma, 4, valid, last, full);
      mb <= advance(mb, 1, valid, last, full);
    end
  end

  task automatic tick();
    @(negedge wclk);
  endtask

  task automatic do_reset();
    valid = '0; last = '0; full = 1'b0; data = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    valid = 4'b1111; data = 32'hDEADBEEF; last = '0; full = 1'b0;
    rst_n = 1'b0;
    tick();
    #1;
    checks++; if (obs_a !== 16'h0) $display("FAIL reset_a obs=%h expected 0000", obs_a); else passes++;
    checks++; if (obs_b !== 16'h0) $display("FAIL reset_b obs=%h expected 0000", obs_b); else passes++;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_alternate();
    int g;
    logic [15:0] e;
    do_reset();
    data = 32'h13121110; last = '0; full = 1'b0; valid = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      g = (k % 2 == 0) ? 0 : 2;
      #1;
      checks++; if (obs_a[15:14] !== 2'b00) $display("FAIL alt_bubble k=%0d busy_wclken=%b expected 00", k, obs_a[15:14]); else passes++;
      tick();
      for (int b = 0; b < 4; b++) begin
        e = {2'b11, 2'(g), 4'(1 << g), 8'(8'h10 + g)};
        #1;
        checks++; if (obs_a !== e) $display("FAIL alt_beat k=%0d b=%0d obs=%h expected %h", k, b, obs_a, e); else passes++;
        tick();
      end
    end
    valid = '0;
  endtask

  task automatic test_two_beat();
    do_reset();
    valid = 4'b0010; data = 32'h0000A100; last = '0;
    #1;
    checks++; if (obs_a !== 16'h0) $display("FAIL two_bubble obs=%h expected 0000", obs_a); else passes++;
    tick();
    #1;
    checks++; if (obs_a !== {2'b11, 2'd1, 4'b0010, 8'hA1}) $display("FAIL two_beat1 obs=%h expected d2a1", obs_a); else passes++;
    tick();
    data = 32'h0000A200; last = 4'b0010;
    #1;
    checks++; if (obs_a !== {2'b11, 2'd1, 4'b0010, 8'hA2}) $display("FAIL two_beat2 obs=%h expected d2a2", obs_a); else passes++;
    tick();
    valid = '0; last = '0;
    #1;
    checks++; if (obs_a !== {2'b00, 2'd1, 4'b0000, 8'h00}) $display("FAIL two_release obs=%h expected 1000", obs_a); else passes++;
    tick();
    valid = 4'b1111;
    #1;
    checks++; if (obs_a[15:14] !== 2'b00) $display("FAIL two_rebubble busy_wclken=%b expected 00", obs_a[15:14]); else passes++;
    tick();
    #1;
    checks++; if (obs_a[15:12] !== {2'b11, 2'd2}) $display("FAIL two_next_ptr obs=%h expected grant 2", obs_a); else passes++;
    tick();
    valid = '0;
  endtask

  task automatic test_wfull();
    do_reset();
    valid = 4'b0001; data = 32'h000000D0; last = '0; full = 1'b0;
    #1;
    checks++; if (obs_a !== 16'h0) $display("FAIL full_bubble obs=%h expected 0000", obs_a); else passes++;
    tick();
    #1;
    checks++; if (obs_a !== {2'b11, 2'd0, 4'b0001, 8'hD0}) $display("FAIL full_beat0 obs=%h expected c1d0", obs_a); else passes++;
    tick();
    data = 32'h000000D1; full = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #1;
      checks++; if (obs_a !== {2'b10, 2'd0, 4'b0000, 8'hD1}) $display("FAIL full_stall s=%0d obs=%h expected 80d1", s, obs_a); else passes++;
      tick();
    end
    full = 1'b0;
    for (int b = 1; b < 4; b++) begin
      data = 32'(8'hD0 + b);
      #1;
      checks++; if (obs_a !== {2'b11, 2'd0, 4'b0001, 8'(8'hD0 + b)}) $display("FAIL full_resume b=%0d obs=%h", b, obs_a); else passes++;
      tick();
    end
    #1;
    checks++; if (obs_a[15:14] !== 2'b00) $display("FAIL full_release busy_wclken=%b expected 00", obs_a[15:14]); else passes++;
    valid = '0;
  endtask

  task automatic test_mb1();
    do_reset();
    valid = 4'b1111; data = 32'h13121110; last = '0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (i % 2 == 0) begin
        checks++; if (obs_b[15:14] !== 2'b00) $display("FAIL mb1_bubble i=%0d busy_wclken=%b expected 00", i, obs_b[15:14]); else passes++;
      end else begin
        checks++; if (obs_b[15:12] !== {2'b11, 2'((i / 2) % 4)}) $display("FAIL mb1_grant i=%0d obs=%h expected grant %0d", i, obs_b, (i / 2) % 4); else passes++;
      end
      tick();
    end
    valid = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    valid = 4'b1000; data = 32'h33000000; last = '0;
    tick();
    tick();
    #1;
    checks++; if (obs_a !== {2'b11, 2'd3, 4'b1000, 8'h33}) $display("FAIL rmid_beat2 obs=%h expected f833", obs_a); else passes++;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (obs_a !== 16'h0) $display("FAIL rmid_async_a obs=%h expected 0000", obs_a); else passes++;
    checks++; if (obs_b !== 16'h0) $display("FAIL rmid_async_b obs=%h expected 0000", obs_b); else passes++;
    tick();
    valid = 4'b1010; data = 32'h33001100;
    rst_n = 1'b1;
    #1;
    checks++; if (obs_a !== 16'h0) $display("FAIL rmid_bubble obs=%h expected 0000", obs_a); else passes++;
    tick();
    #1;
    checks++; if (obs_a !== {2'b11, 2'd1, 4'b0010, 8'h11}) $display("FAIL rmid_first obs=%h expected d211", obs_a); else passes++;
    valid = '0;
  endtask

  task automatic test_valid_drop();
    do_reset();
    valid = 4'b1111; data = 32'h13121110; last = '0;
    tick();
    #1;
    checks++; if (obs_a !== {2'b11, 2'd0, 4'b0001, 8'h10}) $display("FAIL drop_beat obs=%h expected c110", obs_a); else passes++;
    tick();
    valid = 4'b1110;
    for (int s = 0; s < 2; s++) begin
      #1;
      checks++; if (obs_a !== {2'b10, 2'd0, 4'b0000, 8'h10}) $display("FAIL drop_hold s=%0d obs=%h expected 8010", s, obs_a); else passes++;
      tick();
    end
    valid = 4'b1111;
    #1;
    checks++; if (obs_a !== {2'b11, 2'd0, 4'b0001, 8'h10}) $display("FAIL drop_resume obs=%h expected c110", obs_a); else passes++;
    tick();
    valid = '0;
  endtask

  task automatic test_random();
    logic [15:0] ea, eb;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) != 0) valid = 4'($urandom);
      last = 4'($urandom) & 4'($urandom);
      full = ($urandom_range(0, 4) == 0);
      data = $urandom;
      #1;
      ea = expect_out(ma, valid, full, data);
      eb = expect_out(mb, valid, full, data);
      checks++; if (obs_a !== ea) $display("FAIL rand_a c=%0d obs=%h expected %h", c, obs_a, ea); else passes++;
      checks++; if (obs_b !== eb) $display("FAIL rand_b c=%0d obs=%h expected %h", c, obs_b, eb); else passes++;
      tick();
    end
    valid = '0;
  endtask

  initial begin
    rst_n = 1'b0; valid = '0; data = '0; last = '0; full = 1'b0;
    tick();
    test_reset();
    test_alternate();
    test_two_beat();
    test_wfull();
    test_mb1();
    test_reset_mid();
    test_valid_drop();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
